// File: rtl/adc_rx_pkg.sv
// adc_rx_pkg: shared state type and length/width helpers for the multi-lane serial ADC receiver
package adc_rx_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, QUIET} state_t;

    function automatic int frame_len(input int lead, input int data_w, input int trail, input int quiet);
        return lead + data_w + trail + quiet;
    endfunction

    function automatic int cnt_w(input int max_val);
        return max_val < 2 ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_FRAME_LEN = frame_len(1, 12, 1, 4);
    localparam int DEF_POS_W     = cnt_w(DEF_FRAME_LEN - 1);

endpackage

// File: rtl/adc_rx_lane.sv
// adc_rx_lane: one ADC lane's shift register, framing check and averaging accumulator
module adc_rx_lane
    import adc_rx_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int LEAD_BITS = 1,
    parameter int AVG_LOG2  = 0,
    parameter int POS_W     = DEF_POS_W
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              smp,
    input  logic              fin,
    input  logic              clr,
    input  logic              grp_first,
    input  logic              grp_last,
    input  logic [POS_W-1:0]  pos,
    input  logic              miso,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic              is_lead, is_data, ferr, ferr_nx, gerr, gerr_nx;
    logic [DATA_W-1:0] sh, sh_nx;
    logic [ACC_W-1:0]  acc, sum;

    // classify the current bit and form the values as they stand after this edge's sample
    always_comb begin
        is_lead = int'(pos) < LEAD_BITS;
        is_data = !is_lead && int'(pos) < LEAD_BITS + DATA_W;
        sh_nx   = is_data ? DATA_W'({sh, miso}) : sh;
        ferr_nx = (pos == '0 ? 1'b0 : ferr) | (miso & !is_data);
        gerr_nx = (grp_first ? 1'b0 : gerr) | ferr_nx;
        sum     = (grp_first ? '0 : acc) + ACC_W'(sh_nx);
    end

    // shift in every active bit; fold completed kept frames into the group and publish on its last frame
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            sh   <= '0;
            ferr <= 1'b0;
            gerr <= 1'b0;
            acc  <= '0;
            data <= '0;
            err  <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clr) begin
                acc  <= '0;
                gerr <= 1'b0;
            end
            if (smp) begin
                sh   <= sh_nx;
                ferr <= ferr_nx;
            end
            if (fin) begin
                acc  <= sum;
                gerr <= gerr_nx;
                if (grp_last) begin
                    data <= DATA_W'(sum >> AVG_LOG2);
                    err  <= gerr_nx;
                end
            end
        end
    end

endmodule

// File: rtl/adc_serial_rx_multi.sv
// adc_serial_rx_multi: shared-cs_n serial ADC front end capturing N_CH lanes with warm-up discard and averaging
module adc_serial_rx_multi
    import adc_rx_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int DATA_W        = 12,
    parameter int LEAD_BITS     = 1,
    parameter int TRAIL_BITS    = 1,
    parameter int QUIET_CYC     = 4,
    parameter int WARMUP_FRAMES = 3,
    parameter int AVG_LOG2      = 0
) (
    input  logic                   sck,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_CH-1:0]        miso,
    output logic                   cs_n,
    output logic [N_CH*DATA_W-1:0] data_o,
    output logic                   valid_o,
    output logic [N_CH-1:0]        error_o
);

    localparam int ACTIVE_LEN = LEAD_BITS + DATA_W + TRAIL_BITS;
    localparam int FRAME_LEN  = frame_len(LEAD_BITS, DATA_W, TRAIL_BITS, QUIET_CYC);
    localparam int POS_W      = cnt_w(FRAME_LEN - 1);
    localparam int WU_W       = cnt_w(WARMUP_FRAMES);
    localparam int GRP_W      = AVG_LOG2 > 0 ? AVG_LOG2 : 1;

    state_t           state, state_nx;
    logic [POS_W-1:0] pos, pos_nx;
    logic [WU_W-1:0]  wu_cnt;
    logic [GRP_W-1:0] grp_cnt;
    logic             smp, last_bit, end_frm, keep, fin, grp_first, grp_last, clr;

    // frame sequencing: next state and frame position, plus the per-edge strobes for the lanes
    always_comb begin
        smp       = state == ACTIVE;
        last_bit  = smp && pos == POS_W'(ACTIVE_LEN - 1);
        end_frm   = state == QUIET && pos == POS_W'(FRAME_LEN - 1);
        keep      = wu_cnt == WU_W'(WARMUP_FRAMES);
        fin       = last_bit && keep;
        grp_first = grp_cnt == '0;
        grp_last  = grp_cnt == GRP_W'((1 << AVG_LOG2) - 1);
        clr       = state == IDLE;
        state_nx  = state == ACTIVE ? (last_bit ? QUIET : ACTIVE) :
                    state == QUIET  ? (end_frm ? (en ? ACTIVE : IDLE) : QUIET) :
                    (en ? ACTIVE : IDLE);
        pos_nx    = (state == ACTIVE || (state == QUIET && !end_frm)) ? pos + 1'b1 : '0;
    end

    // FSM state, frame position and the registered chip select
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pos   <= '0;
            cs_n  <= 1'b1;
        end else begin
            state <= state_nx;
            pos   <= pos_nx;
            cs_n  <= state_nx != ACTIVE;
        end
    end

    // warm-up discard and averaging-group bookkeeping; both restart whenever the receiver idles
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            wu_cnt  <= '0;
            grp_cnt <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= fin && grp_last;
            if (clr) begin
                wu_cnt  <= '0;
                grp_cnt <= '0;
            end else if (last_bit) begin
                if (!keep)
                    wu_cnt <= wu_cnt + 1'b1;
                else
                    grp_cnt <= grp_last ? '0 : grp_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        adc_rx_lane #(
            .DATA_W   (DATA_W),
            .LEAD_BITS(LEAD_BITS),
            .AVG_LOG2 (AVG_LOG2),
            .POS_W    (POS_W)
        ) u_lane (
            .sck      (sck),
            .rst      (rst),
            .smp      (smp),
            .fin      (fin),
            .clr      (clr),
            .grp_first(grp_first),
            .grp_last (grp_last),
            .pos      (pos),
            .miso     (miso[i]),
            .data     (data_o[i*DATA_W +: DATA_W]),
            .err      (error_o[i])
        );
    end

endmodule
